// File: rtl/execute_controller.sv
// Multi-cycle execute controller: 16x16 register file + PSR around an external ALU.
// Latency 3 cycles accept->done; accepts one instruction per 4 cycles (instr_ready only in IDLE).
module execute_controller #(
    parameter logic [4:0]  PSR_INIT = 5'b00000,
    parameter logic [15:0] REG_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [15:0] alu_opcode,
    output logic        alu_carry_in,
    input  logic [15:0] alu_c,
    input  logic [4:0]  alu_flags,
    output logic [4:0]  psr,
    output logic        done,
    output logic        illegal,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    localparam logic [3:0] OP_RTYPE  = 4'b0000;
    localparam logic [3:0] OP_ADDI   = 4'b0101;
    localparam logic [3:0] OP_SUBI   = 4'b1001;
    localparam logic [3:0] OP_CMPI   = 4'b1011;
    localparam logic [3:0] OP_SHIFTS = 4'b1000;
    localparam logic [3:0] EXT_CMP   = 4'b1011;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [15:0] res_q, res_d;
    logic [4:0]  flags_q, flags_d;
    logic [4:0]  psr_q, psr_d;
    logic [15:0] regs_q [16];
    logic [15:0] regs_d [16];

    logic [3:0]  opcode, rdest, ext, rsrc;
    logic        supported, psr_only;

    assign opcode = instr_q[15:12];
    assign rdest  = instr_q[11:8];
    assign ext    = instr_q[7:4];
    assign rsrc   = instr_q[3:0];

    assign supported = (opcode == OP_RTYPE) || (opcode == OP_ADDI) || (opcode == OP_SUBI) ||
                       (opcode == OP_CMPI)  || (opcode == OP_SHIFTS);
    // Compares only produce flags; their ALU result is meaningless.
    assign psr_only  = (opcode == OP_CMPI) || ((opcode == OP_RTYPE) && (ext == EXT_CMP));

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        flags_d     = flags_q;
        psr_d       = psr_q;
        regs_d      = regs_q;
        instr_ready = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = READ;
                end
            end
            READ: begin
                a_d     = regs_q[rdest];
                b_d     = regs_q[rsrc];
                state_d = EXEC;
            end
            EXEC: begin
                res_d   = alu_c;
                flags_d = alu_flags;
                state_d = WB;
            end
            WB: begin
                done    = 1'b1;
                illegal = !supported;
                if (supported) begin
                    psr_d = flags_q;
                    if (!psr_only) regs_d[rdest] = res_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            instr_q <= 16'h0000;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            res_q   <= 16'h0000;
            flags_q <= 5'b00000;
            psr_q   <= PSR_INIT;
            for (int i = 0; i < 16; i++) regs_q[i] <= REG_INIT;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            psr_q   <= psr_d;
            regs_q  <= regs_d;
        end
    end

    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_opcode   = instr_q;
    assign alu_carry_in = psr_q[0];
    assign psr          = psr_q;
    assign dbg_data     = regs_q[dbg_addr];

endmodule

// File: tb/tb_execute_controller.sv
// Directed bench for execute_controller; the bench itself plays the role of the ALU.
module tb_execute_controller;

    localparam logic [3:0] OP_RTYPE  = 4'b0000;
    localparam logic [3:0] OP_ADDI   = 4'b0101;
    localparam logic [3:0] OP_SUBI   = 4'b1001;
    localparam logic [3:0] OP_CMPI   = 4'b1011;
    localparam logic [3:0] OP_SHIFTS = 4'b1000;
    localparam logic [3:0] EXT_ADD   = 4'b0101;
    localparam logic [3:0] EXT_CMP   = 4'b1011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr = 16'h0000;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] alu_a, alu_b, alu_opcode, alu_c;
    logic        alu_carry_in;
    logic [4:0]  alu_flags, psr;
    logic        done, illegal;
    logic [3:0]  dbg_addr = 4'h0;
    logic [15:0] dbg_data;

    int errors = 0;
    int checks = 0;

    execute_controller dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_carry_in(alu_carry_in), .alu_c(alu_c), .alu_flags(alu_flags), .psr(psr),
        .done(done), .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Reference ALU: flags ordered [NEG, ZERO, FLAG(overflow), LOW, CARRY].
    logic [3:0]  m_op, m_ext;
    logic [15:0] m_imm;
    logic [16:0] m_sum;
    always_comb begin
        m_op      = alu_opcode[15:12];
        m_ext     = alu_opcode[7:4];
        m_imm     = {{8{alu_opcode[7]}}, alu_opcode[7:0]};
        m_sum     = 17'd0;
        alu_c     = 16'hDEAD;
        alu_flags = 5'b11111;
        case (m_op)
            OP_RTYPE: begin
                if (m_ext == EXT_ADD) begin
                    m_sum     = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_carry_in};
                    alu_c     = m_sum[15:0];
                    alu_flags = {m_sum[15], m_sum[15:0] == 16'd0,
                                 (alu_a[15] == alu_b[15]) && (m_sum[15] != alu_a[15]), 1'b0, m_sum[16]};
                end else if (m_ext == EXT_CMP) begin
                    alu_c     = 16'hBEEF;
                    alu_flags = {$signed(alu_a) < $signed(alu_b), alu_a == alu_b, 1'b0, alu_a < alu_b, 1'b0};
                end
            end
            OP_ADDI: begin
                m_sum     = {1'b0, alu_a} + {1'b0, m_imm};
                alu_c     = m_sum[15:0];
                alu_flags = {m_sum[15], m_sum[15:0] == 16'd0,
                             (alu_a[15] == m_imm[15]) && (m_sum[15] != alu_a[15]), 1'b0, m_sum[16]};
            end
            OP_CMPI: begin
                alu_c     = 16'hBEEF;
                alu_flags = {$signed(alu_a) < $signed(m_imm), alu_a == m_imm, 1'b0, alu_a < m_imm, 1'b0};
            end
            OP_SUBI: begin
                alu_c     = alu_a - m_imm;
                alu_flags = 5'b00000;
            end
            OP_SHIFTS: begin
                alu_c     = alu_a << 1;
                alu_flags = 5'b00000;
            end
            default: ;
        endcase
    end

    function automatic logic [15:0] rtype(input logic [3:0] ext, input logic [3:0] rd, input logic [3:0] rs);
        return {OP_RTYPE, rd, ext, rs};
    endfunction

    function automatic logic [15:0] immop(input logic [3:0] op, input logic [3:0] rd, input logic [7:0] imm);
        return {op, rd, imm};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Issue one instruction; lat = cycles from accept edge to done (-1 if none).
    task automatic run_instr(input logic [15:0] ins, output int lat, output logic ill);
        int w;
        lat = -1;
        ill = 1'b0;
        w = 0;
        while (!instr_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (done) begin
                lat = k;
                ill = illegal;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic rd_reg(input logic [3:0] a, output logic [15:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        do_reset();
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
        checks++; if (done !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL reset_pulses: done=%b illegal=%b want 0 0", done, illegal); end
        checks++; if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_opcode !== 16'h0) begin
            errors++; $display("FAIL reset_alu: a=%h b=%h op=%h want 0 0 0", alu_a, alu_b, alu_opcode); end
        checks++; if (psr !== 5'b00000) begin errors++; $display("FAIL reset_psr: got %b want 00000", psr); end
        rd_reg(4'd7, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_reg7: got %h want 0000", v); end
    endtask

    task automatic test_add();
        int lat; logic ill; logic [15:0] v;
        do_reset();
        run_instr(immop(OP_ADDI, 4'd1, 8'd10), lat, ill);
        run_instr(immop(OP_ADDI, 4'd2, 8'd10), lat, ill);
        run_instr(rtype(EXT_ADD, 4'd1, 4'd2), lat, ill);
        checks++; if (lat !== 3) begin errors++; $display("FAIL add_latency: got %0d want 3", lat); end
        checks++; if (ill !== 1'b0) begin errors++; $display("FAIL add_illegal: got %b want 0", ill); end
        rd_reg(4'd1, v);
        checks++; if (v !== 16'd20) begin errors++; $display("FAIL add_r1: got %h want 0014", v); end
        rd_reg(4'd2, v);
        checks++; if (v !== 16'd10) begin errors++; $display("FAIL add_r2: got %h want 000a", v); end
        checks++; if (psr !== 5'b00000) begin errors++; $display("FAIL add_psr: got %b want 00000", psr); end
        run_instr(rtype(EXT_ADD, 4'd1, 4'd1), lat, ill);
        rd_reg(4'd1, v);
        checks++; if (v !== 16'd40) begin errors++; $display("FAIL add_same_reg: got %h want 0028", v); end
        checks++; if (alu_a !== 16'd20 || alu_b !== 16'd20) begin
            errors++; $display("FAIL operand_hold: a=%h b=%h want 0014 0014", alu_a, alu_b); end
    endtask

    task automatic test_carry();
        int lat; logic ill; logic [15:0] v;
        do_reset();
        run_instr(immop(OP_ADDI, 4'd3, 8'd1), lat, ill);
        run_instr(immop(OP_ADDI, 4'd4, 8'd1), lat, ill);
        run_instr(immop(OP_ADDI, 4'd1, 8'hFF), lat, ill);
        run_instr(immop(OP_ADDI, 4'd2, 8'd1), lat, ill);
        run_instr(rtype(EXT_ADD, 4'd1, 4'd2), lat, ill);
        rd_reg(4'd1, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL carry_r1: got %h want 0000", v); end
        checks++; if (psr !== 5'b01001) begin errors++; $display("FAIL carry_psr: got %b want 01001", psr); end
        checks++; if (alu_carry_in !== 1'b1) begin errors++; $display("FAIL carry_in: got %b want 1", alu_carry_in); end
        run_instr(rtype(EXT_ADD, 4'd3, 4'd4), lat, ill);
        rd_reg(4'd3, v);
        checks++; if (v !== 16'd3) begin errors++; $display("FAIL carry_consumed: got %h want 0003", v); end
        checks++; if (psr !== 5'b00000) begin errors++; $display("FAIL carry_psr2: got %b want 00000", psr); end
    endtask

    task automatic test_cmp();
        int lat; logic ill; logic [15:0] v;
        do_reset();
        run_instr(immop(OP_CMPI, 4'd5, 8'd1), lat, ill);
        checks++; if (lat !== 3) begin errors++; $display("FAIL cmpi_latency: got %0d want 3", lat); end
        rd_reg(4'd5, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL cmpi_r5: got %h want 0000", v); end
        checks++; if (psr !== 5'b10010) begin errors++; $display("FAIL cmpi_psr: got %b want 10010", psr); end
        run_instr(immop(OP_ADDI, 4'd6, 8'd7), lat, ill);
        run_instr(rtype(EXT_CMP, 4'd6, 4'd5), lat, ill);
        rd_reg(4'd6, v);
        checks++; if (v !== 16'd7) begin errors++; $display("FAIL cmp_r6: got %h want 0007", v); end
        checks++; if (psr !== 5'b00000) begin errors++; $display("FAIL cmp_psr: got %b want 00000", psr); end
    endtask

    task automatic test_back_to_back();
        int acc, dn, bad; logic [15:0] v;
        do_reset();
        acc = 0; dn = 0; bad = 0;
        instr = immop(OP_ADDI, 4'd7, 8'd1);
        instr_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (instr_ready) begin
                acc++;
                if (c % 4 != 0) bad++;
            end
            if (done) dn++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (done) dn++;
            @(negedge clk);
        end
        checks++; if (acc !== 10) begin errors++; $display("FAIL b2b_accepts: got %0d want 10", acc); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_spacing: got %0d early readies want 0", bad); end
        checks++; if (dn !== 10) begin errors++; $display("FAIL b2b_dones: got %0d want 10", dn); end
        rd_reg(4'd7, v);
        checks++; if (v !== 16'd10) begin errors++; $display("FAIL b2b_r7: got %h want 000a", v); end
    endtask

    task automatic test_reset_abort();
        int lat, dn; logic ill; logic [15:0] v;
        do_reset();
        run_instr(immop(OP_ADDI, 4'd1, 8'd10), lat, ill);
        run_instr(immop(OP_ADDI, 4'd2, 8'd10), lat, ill);
        instr = rtype(EXT_ADD, 4'd1, 4'd2);
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        checks++; if (alu_a !== 16'd10 || alu_b !== 16'd10) begin
            errors++; $display("FAIL abort_exec_operands: a=%h b=%h want 000a 000a", alu_a, alu_b); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", instr_ready); end
        dn = 0;
        for (int c = 0; c < 5; c++) begin
            if (done) dn++;
            @(negedge clk);
        end
        checks++; if (dn !== 0) begin errors++; $display("FAIL abort_done: got %0d pulses want 0", dn); end
        rd_reg(4'd1, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL abort_r1: got %h want 0000", v); end
    endtask

    task automatic test_illegal();
        int lat; logic ill; logic [15:0] v;
        do_reset();
        run_instr(immop(OP_ADDI, 4'd1, 8'd9), lat, ill);
        run_instr(immop(OP_CMPI, 4'd5, 8'd1), lat, ill);
        run_instr(16'hF123, lat, ill);
        checks++; if (lat !== 3) begin errors++; $display("FAIL illegal_latency: got %0d want 3", lat); end
        checks++; if (ill !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %b want 1", ill); end
        checks++; if (done !== 1'b0 || illegal !== 1'b0) begin
            errors++; $display("FAIL illegal_pulse_width: done=%b illegal=%b want 0 0", done, illegal); end
        rd_reg(4'd1, v);
        checks++; if (v !== 16'd9) begin errors++; $display("FAIL illegal_r1: got %h want 0009", v); end
        checks++; if (psr !== 5'b10010) begin errors++; $display("FAIL illegal_psr: got %b want 10010", psr); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry();
        test_cmp();
        test_back_to_back();
        test_reset_abort();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/execute_controller.md
EXECUTE_CONTROLLER -- requirements
Module: execute_controller

Interface — parameters
REQ-001 SHALL have parameter PSR_INIT, default 5'b00000: PSR value loaded on reset, ordered [NEG, ZERO, FLAG, LOW, CARRY].
REQ-002 SHALL have parameter REG_INIT, default 16'h0000: value loaded into every register-file entry on reset.

Interface — ports
REQ-003 SHALL have one clock and a synchronous, active-high reset; all state changes occur on the rising edge of the clock.
REQ-004 clk  in  1  system clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 instr  in  16  instruction: [15:12] opcode, [11:8] Rdest, [7:4] ext/imm-high, [3:0] Rsrc/imm-low.
REQ-007 instr_valid  in  1  instr is presented.
REQ-008 instr_ready  out  1  controller can accept instr.
REQ-009 alu_a  out  16  ALU operand a, equal to reg[Rdest].
REQ-010 alu_b  out  16  ALU operand b, equal to reg[Rsrc].
REQ-011 alu_opcode  out  16  latched instruction word.
REQ-012 alu_carry_in  out  1  PSR CARRY bit.
REQ-013 alu_c  in  16  ALU result.
REQ-014 alu_flags  in  5  ALU flags [NEG, ZERO, FLAG, LOW, CARRY].
REQ-015 psr  out  5  current PSR.
REQ-016 done  out  1  one-cycle pulse at instruction retire.
REQ-017 illegal  out  1  one-cycle pulse, coincident with done, for an unsupported opcode.
REQ-018 dbg_addr  in  4  debug register select.
REQ-019 dbg_data  out  16  combinational read of reg[dbg_addr].

Function
REQ-020 SHALL contain a 16x16 register file and a 5-bit PSR.
REQ-021 SHALL implement the FSM states IDLE, READ, EXEC and WB with transitions IDLE->READ on instr_valid&&instr_ready, READ->EXEC, EXEC->WB and WB->IDLE, each unconditional.
REQ-022 instr_ready SHALL be 1 only in IDLE; instr SHALL be captured into an instruction latch on the accepting edge and ignored at all other times.
REQ-023 In READ, SHALL latch reg[Rdest] and reg[Rsrc] into operand registers that drive alu_a and alu_b from EXEC onward.
REQ-024 alu_opcode SHALL equal the instruction latch and alu_carry_in SHALL equal PSR[0] throughout EXEC.
REQ-025 At the end of EXEC, SHALL capture alu_c and alu_flags into result and flag registers.
REQ-026 In WB, SHALL write the result to reg[Rdest] and the flags to the PSR, and SHALL assert done.
REQ-027 Latency from accept edge to done SHALL be 3 cycles; the next accept SHALL occur no earlier than 4 cycles after the previous one.
REQ-028 Supported opcodes are `RTYPE, `ADDI, `SUBI, `CMPI and `SHIFTS.
REQ-029 For `CMPI, and for `RTYPE with ext = `EXT_CMP, SHALL update the PSR only, with no register write.
REQ-030 For an unsupported opcode, SHALL perform no register write and no PSR update, and SHALL assert illegal with done.
REQ-031 When Rdest == Rsrc, both operands SHALL read the same pre-instruction value.
REQ-032 Register-file and PSR updates SHALL take effect in the cycle after WB, so a following instruction's READ sees the new values.
REQ-033 dbg_data SHALL reflect register writes from the cycle after WB.
REQ-034 alu_a and alu_b SHALL hold their last value outside EXEC.

Reset
REQ-035 When reset is asserted in any state, SHALL enter IDLE on the next edge and abort any in-flight instruction with no write and no done.
REQ-036 Reset SHALL load the PSR with PSR_INIT and every register with REG_INIT.
REQ-037 Reset values: instr_ready=1 in the cycle after reset, done=0, illegal=0, alu_a=0, alu_b=0, alu_opcode=0.
REQ-038 Reset SHALL take priority over instr_valid in the same cycle.

Verification
REQ-039 Bench SHALL cover: R1=10, R2=10, issue RTYPE ADD R1,R2 -> done 3 cycles after accept, R1=20, psr=00000.
REQ-040 Bench SHALL cover: R1=FFFF, R2=1, ADD, then R3=1, R4=1, ADD R3,R4 -> first instruction psr CARRY=1, then R3=3 (carry consumed).
REQ-041 Bench SHALL cover: R5=0, CMPI R5,#1 -> R5 unchanged at 0, psr NEG=1 and LOW=1, no register write.
REQ-042 Bench SHALL cover: instr_valid held high continuously -> instr_ready asserted only 1 of every 4 cycles, and done count equals accept count.
REQ-043 Bench SHALL cover: reset asserted in EXEC of ADD R1,R2 -> no write to R1, no done, IDLE with instr_ready=1 next cycle.
REQ-044 Bench SHALL cover: opcode 4'b1111 issued -> done and illegal both pulse, registers and psr unchanged.
